// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 frame receiver with edge filter, timeout and error strobes.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_ctrl #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] clk_sr, data_sr;
  logic filt, filt_n, f_tick, data_s, par_ok;
  logic [9:0] sreg, sreg_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] tmo, tmo_n;
  logic [7:0] dout_n;
  logic done_n, ferr_n, perr_n;
  // Filtered level only moves on two agreeing samples, so a 1-cycle glitch never ticks
  assign filt_n = (clk_sr == 2'b11) ? 1'b1 : (clk_sr == 2'b00) ? 1'b0 : filt;
  assign f_tick = filt & ~filt_n;
  assign data_s = data_sr[1];
`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^sreg[8:0];
`else
  assign par_ok = 1'b1;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_sr       <= '0;
      data_sr      <= '0;
      filt         <= 1'b0;
      state        <= IDLE;
      sreg         <= '0;
      bit_cnt      <= '0;
      tmo          <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      clk_sr       <= {clk_sr[0], ps2_clk};
      data_sr      <= {data_sr[0], ps2_data};
      filt         <= filt_n;
      state        <= state_n;
      sreg         <= sreg_n;
      bit_cnt      <= bit_cnt_n;
      tmo          <= tmo_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
      parity_err   <= perr_n;
      busy         <= state_n != IDLE;
    end
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    tmo_n     = tmo;
    dout_n    = dout;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
    case (state)
      IDLE:
        if (f_tick && rx_en && !data_s) begin
          state_n   = DATA;
          bit_cnt_n = 4'd9;
          tmo_n     = '0;
        end
      DATA:
        if (f_tick) begin
          sreg_n    = {data_s, sreg[9:1]};
          tmo_n     = '0;
          bit_cnt_n = (bit_cnt == 4'd0) ? bit_cnt : bit_cnt - 4'd1;
          state_n   = (bit_cnt == 4'd0) ? CHECK : DATA;
        end else if (tmo == TMO_MAX) begin
          state_n = IDLE;
          ferr_n  = 1'b1;
        end else
          tmo_n = tmo + 1'b1;
      CHECK: begin
        state_n = IDLE;
        ferr_n  = ~sreg[9];
        perr_n  = sreg[9] & ~par_ok;
        done_n  = sreg[9] & par_ok;
        dout_n  = (sreg[9] && par_ok) ? sreg[7:0] : dout;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb_ps2_rx_ctrl: directed and random PS/2 frames checked against a frame-level model.
module tb_ps2_rx_ctrl;
  localparam int TMO = 5000;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, rx_en = 0;
  logic [7:0] dout;
  logic rx_done_tick, frame_err, parity_err, busy;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_done = 0, n_ferr = 0, n_perr = 0, done_cyc = -1, ferr_cyc = -1;
  int e_done = 0, e_ferr = 0, e_perr = 0, e_dout = 0, last_fall = 0;
  int f0, k;
  bit par_chk, busy_seen;

  ps2_rx_ctrl dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx_en(rx_en),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      if (rx_done_tick) begin n_done++; done_cyc = cyc; end
      if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
      if (parity_err) n_perr++;
      if (busy) busy_seen = 1;
    end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat ($urandom_range(15, 25)) @(negedge clk);
  endtask

  // Drives nbits of a frame; the model decides the outcome from the frame's bits alone
  task automatic send(input logic [7:0] d, input bit flip, input bit stop, input int nbits, input bit drop);
    logic [10:0] b;
    bit acc;
    b = {stop, (~^d) ^ flip, d, 1'b0};
    acc = rx_en;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      half();
      ps2_clk = 0;
      last_fall = cyc;
      half();
      ps2_clk = 1;
      if (drop && i == 0) rx_en = 0;
    end
    ps2_data = 1;
    if (acc && nbits == 11) begin
      if (!stop) e_ferr++;
      else if (par_chk && flip) e_perr++;
      else begin e_done++; e_dout = int'(d); end
    end
    half();
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "/done"}, n_done, e_done);
    chk({tag, "/ferr"}, n_ferr, e_ferr);
    chk({tag, "/perr"}, n_perr, e_perr);
    chk({tag, "/dout"}, int'(dout), e_dout);
    chk({tag, "/busy"}, int'(busy), 0);
  endtask

  initial begin
`ifdef PS2_PARITY_CHECK_EN
    par_chk = 1;
`else
    par_chk = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst/dout", int'(dout), 0);
    chk("rst/done", int'(rx_done_tick), 0);
    chk("rst/ferr", int'(frame_err), 0);
    chk("rst/perr", int'(parity_err), 0);
    chk("rst/busy", int'(busy), 0);
    rst = 0;
    repeat (5) @(negedge clk);
    rx_en = 1;
    send(8'h1C, 0, 1, 11, 0);
    chk("t1/latency", done_cyc, last_fall + 4);
    settle("t1");
    send(8'hF0, 0, 1, 11, 0);
    settle("t2a");
    send(8'h1C, 0, 1, 11, 0);
    settle("t2b");
    send(8'h1C, 0, 0, 11, 0);
    chk("t3/latency", ferr_cyc, last_fall + 4);
    settle("t3");
    send(8'h5A, 0, 1, 11, 0);
    send(8'h1C, 1, 1, 11, 0);
    settle("t4");
    send(8'h33, 0, 1, 5, 0);
    f0 = n_ferr;
    k = 0;
    while (n_ferr == f0 && k < TMO + 100) begin @(negedge clk); k++; end
    e_ferr++;
    chk("t5/tmo_cyc", ferr_cyc, last_fall + TMO + 3);
    settle("t5");
    send(8'hA5, 0, 1, 11, 0);
    settle("t5b");
    send(8'h77, 0, 1, 4, 0);
    chk("t6/busy_mid", int'(busy), 1);
    @(negedge clk);
    #3 rst = 1;
    #1;
    chk("t6/rst_dout", int'(dout), 0);
    chk("t6/rst_busy", int'(busy), 0);
    e_dout = 0;
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    settle("t6a");
    rx_en = 0;
    busy_seen = 0;
    send(8'h1C, 0, 1, 11, 0);
    settle("t6b");
    chk("t6b/busy_seen", int'(busy_seen), 0);
    rx_en = 1;
    ps2_data = 0;
    repeat (4) @(negedge clk);
    ps2_clk = 0;
    @(negedge clk);
    ps2_clk = 1;
    repeat (6) @(negedge clk);
    ps2_data = 1;
    chk("t6c/glitch", int'(busy_seen), 0);
    settle("t6c");
    send(8'h3C, 0, 1, 11, 1);
    settle("t7");
    rx_en = 1;
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 11, 0);
      settle("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
